// File: rtl/cnn_sched_pkg.sv
// cnn_sched_pkg: shared defaults, FSM state encoding and latched layer config for cnn_tile_sched
package cnn_sched_pkg;
    localparam int ADDR_W_DEF   = 32;
    localparam int OFFSET_W_DEF = 16;
    localparam int CNT_W_DEF    = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONF,
        S_REQ,
        S_RUN,
        S_FINAL,
        S_NEXT,
        S_DONE
    } sched_state_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0]   base_addr;
        logic [ADDR_W_DEF-1:0]   tile_step;
        logic [ADDR_W_DEF-1:0]   chan_step;
        logic [OFFSET_W_DEF-1:0] row_gap;
        logic [CNT_W_DEF-1:0]    num_tiles;
        logic [CNT_W_DEF-1:0]    num_chans;
    } layer_cfg_t;
endpackage

// File: rtl/cnn_sched_addr_gen.sv
// cnn_sched_addr_gen: tile/channel counters and buffer start address for the layer scheduler
// Ports:
//   load                      restart at base_addr, counters to 0
//   adv                       step to the next tile (wraps into the next channel)
//   base_addr/tile_step/chan_step, num_tiles/num_chans   latched layer geometry
//   prev_vld/prev_addr        last issued conf_addr, for reuse detection
//   cur_addr, tile_idx, chan_idx                         current position
//   last_tile, last_chan      position flags for the FSM
//   reuse_hit                 address after this advance equals prev_addr
module cnn_sched_addr_gen
    import cnn_sched_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              adv,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] tile_step,
    input  logic [ADDR_W-1:0] chan_step,
    input  logic [CNT_W-1:0]  num_tiles,
    input  logic [CNT_W-1:0]  num_chans,
    input  logic              prev_vld,
    input  logic [ADDR_W-1:0] prev_addr,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [CNT_W-1:0]  tile_idx,
    output logic [CNT_W-1:0]  chan_idx,
    output logic              last_tile,
    output logic              last_chan,
    output logic              reuse_hit
);
    logic [ADDR_W-1:0] cur_addr_d, cur_addr_q, chan_base_d, chan_base_q;
    logic [CNT_W-1:0]  tile_idx_d, tile_idx_q, chan_idx_d, chan_idx_q;

    assign last_tile = tile_idx_q == num_tiles - CNT_W'(1);
    assign last_chan = chan_idx_q == num_chans - CNT_W'(1);

    always_comb begin
        cur_addr_d  = cur_addr_q;
        chan_base_d = chan_base_q;
        tile_idx_d  = tile_idx_q;
        chan_idx_d  = chan_idx_q;
        if (load) begin
            cur_addr_d  = base_addr;
            chan_base_d = base_addr;
            tile_idx_d  = '0;
            chan_idx_d  = '0;
        end else if (adv && last_tile) begin
            tile_idx_d  = '0;
            chan_idx_d  = chan_idx_q + CNT_W'(1);
            chan_base_d = chan_base_q + chan_step;
            cur_addr_d  = chan_base_d;
        end else if (adv) begin
            tile_idx_d  = tile_idx_q + CNT_W'(1);
            cur_addr_d  = cur_addr_q + tile_step;
        end
    end

    // Compared against the post-advance address so the FSM can skip CONF on the same edge.
    assign reuse_hit = prev_vld && (cur_addr_d == prev_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr_q  <= '0;
            chan_base_q <= '0;
            tile_idx_q  <= '0;
            chan_idx_q  <= '0;
        end else begin
            cur_addr_q  <= cur_addr_d;
            chan_base_q <= chan_base_d;
            tile_idx_q  <= tile_idx_d;
            chan_idx_q  <= chan_idx_d;
        end
    end

    assign cur_addr = cur_addr_q;
    assign tile_idx = tile_idx_q;
    assign chan_idx = chan_idx_q;
endmodule

// File: rtl/cnn_tile_sched.sv
// cnn_tile_sched: sequences one conv layer through the window buffer, tile by tile, channel by channel
// Ports:
//   start/abort               launch (IDLE only) / terminate the layer
//   cfg_*                     layer geometry, latched on start
//   conf_addr_valid/conf_addr, conf_offset_valid/conf_offset   buffer programming
//   buf_req/buf_refresh/buf_req_final, window_finish          buffer handshake
//   busy/done, tile_idx/chan_idx                              status
// Optional: define CNN_SCHED_ADDR_REUSE_EN to skip CONF and suppress buf_refresh
//   when a tile's address equals the previously issued conf_addr.
module cnn_tile_sched
    import cnn_sched_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int OFFSET_W = OFFSET_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   cfg_base_addr,
    input  logic [ADDR_W-1:0]   cfg_tile_step,
    input  logic [ADDR_W-1:0]   cfg_chan_step,
    input  logic [OFFSET_W-1:0] cfg_row_gap,
    input  logic [CNT_W-1:0]    cfg_num_tiles,
    input  logic [CNT_W-1:0]    cfg_num_chans,
    output logic                conf_addr_valid,
    output logic [ADDR_W-1:0]   conf_addr,
    output logic                conf_offset_valid,
    output logic [OFFSET_W-1:0] conf_offset,
    output logic                buf_req,
    output logic                buf_refresh,
    output logic                buf_req_final,
    input  logic                window_finish,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    tile_idx,
    output logic [CNT_W-1:0]    chan_idx
);
    sched_state_e      state_d, state_q;
    layer_cfg_t        cfg_d, cfg_q;
    logic              abort_d, abort_q, skip_d, skip_q;
    logic              launch, adv, last_tile, last_chan, reuse_hit, prev_vld;
    logic [ADDR_W-1:0] cur_addr, prev_addr;

    assign launch = state_q == S_IDLE && start;
    assign cfg_d  = launch ? '{base_addr: cfg_base_addr, tile_step: cfg_tile_step,
                               chan_step: cfg_chan_step, row_gap: cfg_row_gap,
                               num_tiles: cfg_num_tiles, num_chans: cfg_num_chans} : cfg_q;

    cnn_sched_addr_gen #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (launch),
        .adv       (adv),
        .base_addr (cfg_d.base_addr),
        .tile_step (cfg_q.tile_step),
        .chan_step (cfg_q.chan_step),
        .num_tiles (cfg_q.num_tiles),
        .num_chans (cfg_q.num_chans),
        .prev_vld  (prev_vld),
        .prev_addr (prev_addr),
        .cur_addr  (cur_addr),
        .tile_idx  (tile_idx),
        .chan_idx  (chan_idx),
        .last_tile (last_tile),
        .last_chan (last_chan),
        .reuse_hit (reuse_hit)
    );

    // abort_q remembers an abort taken from RUN so FINAL exits to DONE instead of NEXT.
    // skip_q marks a REQ entered without CONF, i.e. the buffer keeps its resident data.
    always_comb begin
        state_d = state_q;
        abort_d = abort_q;
        skip_d  = skip_q;
        adv     = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = (cfg_num_tiles == '0 || cfg_num_chans == '0) ? S_DONE : S_CONF;
                abort_d = 1'b0;
                skip_d  = 1'b0;
            end
            S_CONF:  state_d = abort ? S_DONE : S_REQ;
            S_REQ:   state_d = abort ? S_DONE : S_RUN;
            S_RUN: begin
                abort_d = abort;
                state_d = (abort || window_finish) ? S_FINAL : S_RUN;
            end
            S_FINAL: state_d = (abort_q || abort) ? S_DONE : S_NEXT;
            S_NEXT: if (abort || (last_tile && last_chan)) begin
                state_d = S_DONE;
            end else begin
                adv     = 1'b1;
                skip_d  = reuse_hit;
                state_d = reuse_hit ? S_REQ : S_CONF;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cfg_q   <= '0;
            abort_q <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            abort_q <= abort_d;
            skip_q  <= skip_d;
        end
    end

`ifdef CNN_SCHED_ADDR_REUSE_EN
    logic              prev_vld_d, prev_vld_q;
    logic [ADDR_W-1:0] prev_addr_d, prev_addr_q;

    always_comb begin
        prev_vld_d  = prev_vld_q;
        prev_addr_d = prev_addr_q;
        if (launch) begin
            prev_vld_d  = 1'b0;
            prev_addr_d = '0;
        end else if (state_q == S_CONF) begin
            prev_vld_d  = 1'b1;
            prev_addr_d = cur_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_vld_q  <= 1'b0;
            prev_addr_q <= '0;
        end else begin
            prev_vld_q  <= prev_vld_d;
            prev_addr_q <= prev_addr_d;
        end
    end

    assign prev_vld  = prev_vld_q;
    assign prev_addr = prev_addr_q;
`else
    assign prev_vld  = 1'b0;
    assign prev_addr = '0;
`endif

    assign busy              = state_q != S_IDLE;
    assign conf_addr_valid   = state_q == S_CONF;
    assign conf_addr         = conf_addr_valid ? cur_addr : '0;
    assign conf_offset_valid = state_q inside {S_CONF, S_REQ, S_RUN, S_FINAL};
    assign conf_offset       = conf_offset_valid ? cfg_q.row_gap : '0;
    assign buf_req           = state_q == S_REQ;
    assign buf_refresh       = buf_req && !skip_q;
    assign buf_req_final     = state_q == S_FINAL;
    assign done              = state_q == S_DONE;
endmodule

// File: tb/tb_cnn_tile_sched.sv
// tb_cnn_tile_sched: directed self-checking bench for cnn_tile_sched
module tb_cnn_tile_sched;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [31:0] cfg_base_addr = '0, cfg_tile_step = '0, cfg_chan_step = '0;
    logic [15:0] cfg_row_gap = '0;
    logic [7:0]  cfg_num_tiles = '0, cfg_num_chans = '0;
    logic        conf_addr_valid, conf_offset_valid, buf_req, buf_refresh, buf_req_final;
    logic        busy, done, window_finish;
    logic [31:0] conf_addr;
    logic [15:0] conf_offset;
    logic [7:0]  tile_idx, chan_idx;
    logic        auto_fin = 1'b1, af = 1'b0, mf = 1'b0;
    int          fin_cnt = 0;
    int          checks = 0, errors = 0;
    int          n_req = 0, n_fin = 0, n_done = 0, n_conf = 0;
    logic [31:0] conf_q[$];
    logic        ref_q[$];
    logic [31:0] exp_addr [6] = '{32'h1000, 32'h1040, 32'h1080, 32'h1400, 32'h1440, 32'h1480};
    logic        exp_ref [3];

    assign window_finish = (af & auto_fin) | mf;

    cnn_tile_sched dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .abort             (abort),
        .cfg_base_addr     (cfg_base_addr),
        .cfg_tile_step     (cfg_tile_step),
        .cfg_chan_step     (cfg_chan_step),
        .cfg_row_gap       (cfg_row_gap),
        .cfg_num_tiles     (cfg_num_tiles),
        .cfg_num_chans     (cfg_num_chans),
        .conf_addr_valid   (conf_addr_valid),
        .conf_addr         (conf_addr),
        .conf_offset_valid (conf_offset_valid),
        .conf_offset       (conf_offset),
        .buf_req           (buf_req),
        .buf_refresh       (buf_refresh),
        .buf_req_final     (buf_req_final),
        .window_finish     (window_finish),
        .busy              (busy),
        .done              (done),
        .tile_idx          (tile_idx),
        .chan_idx          (chan_idx)
    );

    always #5 clk = ~clk;

    // Buffer model raises window_finish for one cycle, 10 cycles after each buf_req; also logs strobes.
    always @(negedge clk) begin
        af = 1'b0;
        if (fin_cnt > 0) begin
            fin_cnt = fin_cnt - 1;
            if (fin_cnt == 0) af = 1'b1;
        end
        if (buf_req) begin
            fin_cnt = 10;
            n_req = n_req + 1;
            ref_q.push_back(buf_refresh);
        end
        if (conf_addr_valid) begin
            n_conf = n_conf + 1;
            conf_q.push_back(conf_addr);
        end
        if (buf_req_final) n_fin = n_fin + 1;
        if (done) n_done = n_done + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_cfg(input logic [31:0] b, input logic [31:0] t, input logic [31:0] c,
                           input logic [15:0] g, input logic [7:0] nt, input logic [7:0] nc);
        cfg_base_addr = b;
        cfg_tile_step = t;
        cfg_chan_step = c;
        cfg_row_gap   = g;
        cfg_num_tiles = nt;
        cfg_num_chans = nc;
    endtask

    task automatic wait_done(input int max, input string tag);
        int k = 0;
        while (!done && k < max) begin
            cyc(1);
            k++;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_req(input logic [7:0] idx, input int max, input string tag);
        int k = 0;
        while (!(buf_req && tile_idx == idx) && k < max) begin
            cyc(1);
            k++;
        end
        chk({tag, "_req"}, {31'd0, buf_req}, 32'd1);
    endtask

    initial begin
        int r0, f0, d0, q0, c0, rq0;
        cyc(3);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_strobes", {26'd0, conf_addr_valid, conf_offset_valid, buf_req, buf_refresh, buf_req_final, done}, 32'd0);
        chk("rst_idx", {16'd0, tile_idx, chan_idx}, 32'd0);
        chk("rst_addr", conf_addr, 32'd0);
        rst = 1'b0;
        cyc(1);

        // Basic run: 3 tiles x 2 channels
        set_cfg(32'h1000, 32'h40, 32'h400, 16'h20, 8'd3, 8'd2);
        r0 = n_req; f0 = n_fin; d0 = n_done; q0 = conf_q.size();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("b_conf_v", {31'd0, conf_addr_valid}, 32'd1);
        chk("b_conf_a", conf_addr, 32'h1000);
        chk("b_offset", {15'd0, conf_offset_valid, conf_offset}, {15'd0, 1'b1, 16'h20});
        chk("b_busy", {31'd0, busy}, 32'd1);
        set_cfg(32'hdead0000, 32'h4, 32'h8, 16'h7, 8'd1, 8'd1);
        cyc(1);
        chk("b_req", {30'd0, buf_req, buf_refresh}, 32'd3);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_done(400, "b");
        chk("b_idx_end", {16'd0, tile_idx, chan_idx}, {16'd0, 8'd2, 8'd1});
        cyc(1);
        chk("b_done_pulse", {30'd0, done, busy}, 32'd0);
        chk("b_nreq", n_req - r0, 32'd6);
        chk("b_nfin", n_fin - f0, 32'd6);
        chk("b_ndone", n_done - d0, 32'd1);
        chk("b_nconf", conf_q.size() - q0, 32'd6);
        for (int i = 0; i < 6; i++) chk($sformatf("b_addr%0d", i), conf_q[q0 + i], exp_addr[i]);

        // Zero tile count: straight to DONE
        set_cfg(32'h1000, 32'h40, 32'h400, 16'h20, 8'd0, 8'd2);
        r0 = n_req;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("z_done", {30'd0, done, busy}, 32'd3);
        cyc(1);
        chk("z_idle", {30'd0, done, busy}, 32'd0);
        chk("z_nreq", n_req - r0, 32'd0);

        // window_finish during REQ is ignored
        auto_fin = 1'b0;
        set_cfg(32'h500, 32'h10, 32'h100, 16'h4, 8'd1, 8'd1);
        f0 = n_fin;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        chk("e_in_req", {31'd0, buf_req}, 32'd1);
        mf = 1'b1;
        cyc(1);
        mf = 1'b0;
        chk("e_run", {30'd0, busy, buf_req_final}, 32'd2);
        cyc(3);
        chk("e_wait", {30'd0, conf_offset_valid, buf_req_final}, 32'd2);
        mf = 1'b1;
        cyc(1);
        mf = 1'b0;
        chk("e_final", {31'd0, buf_req_final}, 32'd1);
        cyc(1);
        chk("e_next", {30'd0, buf_req_final, conf_offset_valid}, 32'd0);
        cyc(1);
        chk("e_done", {31'd0, done}, 32'd1);
        chk("e_nfin", n_fin - f0, 32'd1);
        auto_fin = 1'b1;
        cyc(2);

        // Abort in RUN of tile 1
        set_cfg(32'h8000, 32'h40, 32'h400, 16'h0, 8'd3, 8'd1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_req(8'd1, 200, "a");
        cyc(1);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("a_final", {31'd0, buf_req_final}, 32'd1);
        cyc(1);
        chk("a_done", {23'd0, done, tile_idx}, {23'd0, 1'b1, 8'd1});
        cyc(12);
        chk("a_hold", {23'd0, busy, tile_idx}, {23'd0, 1'b0, 8'd1});

        // Abort in CONF: no request, no final
        set_cfg(32'h9000, 32'h40, 32'h400, 16'h0, 8'd2, 8'd1);
        r0 = n_req; f0 = n_fin;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("ac_done", {30'd0, done, buf_req_final}, 32'd2);
        cyc(1);
        chk("ac_nreq", n_req - r0, 32'd0);
        chk("ac_nfin", n_fin - f0, 32'd0);

        // start and abort together in IDLE, then reset during tile 2 RUN
        set_cfg(32'h2000, 32'h100, 32'h0, 16'h8, 8'd3, 8'd1);
        start = 1'b1;
        abort = 1'b1;
        cyc(1);
        start = 1'b0;
        abort = 1'b0;
        chk("sa_conf_v", {31'd0, conf_addr_valid}, 32'd1);
        chk("sa_conf_a", conf_addr, 32'h2000);
        wait_req(8'd2, 300, "r");
        cyc(1);
        f0 = n_fin;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("r_busy", {31'd0, busy}, 32'd0);
        chk("r_strobes", {26'd0, conf_addr_valid, conf_offset_valid, buf_req, buf_refresh, buf_req_final, done}, 32'd0);
        chk("r_idx", {16'd0, tile_idx, chan_idx}, 32'd0);
        cyc(12);
        chk("r_nofinal", n_fin - f0, 32'd0);
        set_cfg(32'h3000, 32'h40, 32'h400, 16'h8, 8'd1, 8'd1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("r_restart", conf_addr, 32'h3000);
        wait_done(100, "r");
        cyc(1);

        // Zero tile step: address reuse behaviour depends on the build
        set_cfg(32'h4000, 32'h0, 32'h100, 16'h8, 8'd3, 8'd1);
        c0 = n_conf; r0 = n_req; rq0 = ref_q.size();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_done(200, "u");
        cyc(1);
`ifdef CNN_SCHED_ADDR_REUSE_EN
        exp_ref = '{1'b1, 1'b0, 1'b0};
        chk("u_nconf", n_conf - c0, 32'd1);
`else
        exp_ref = '{1'b1, 1'b1, 1'b1};
        chk("u_nconf", n_conf - c0, 32'd3);
`endif
        chk("u_nreq", n_req - r0, 32'd3);
        for (int i = 0; i < 3; i++) chk($sformatf("u_refresh%0d", i), {31'd0, ref_q[rq0 + i]}, {31'd0, exp_ref[i]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
